// File: rtl/axis_frame_fifo_ex_if.sv
// AXI-Stream bundle shared by the slave and master sides of the frame FIFO.
interface axis_frame_fifo_ex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_fifo_ex.sv
// AXI-Stream frame FIFO: beats are buffered and only released to the master
// side once their frame's tlast has been committed. Bad, oversize and
// overflowing frames are discarded and counted.
module axis_frame_fifo_ex #(
    parameter int DEPTH          = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_ENABLE      = 0,
    parameter int ID_WIDTH       = 8,
    parameter int DEST_ENABLE    = 0,
    parameter int DEST_WIDTH     = 8,
    parameter int USER_ENABLE    = 1,
    parameter int USER_WIDTH     = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
    parameter int DROP_BAD_FRAME = 0,
    parameter int DROP_WHEN_FULL = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axis_frame_fifo_ex_if.slave     s_axis,
    axis_frame_fifo_ex_if.master    m_axis,
    output logic [$clog2(DEPTH):0]  status_frame_count,
    output logic                    status_overflow,
    output logic                    status_bad_frame,
    output logic                    status_good_frame,
    output logic [CNT_WIDTH-1:0]    drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [DEST_WIDTH-1:0] dest;
        logic [ID_WIDTH-1:0]   id;
        logic [KEEP_WIDTH-1:0] keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t mem [DEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 drop_frame_q, drop_frame_d;
    logic                 m_valid_q, m_valid_d;
    beat_t                out_q, out_d;
    logic [PW-1:0]        frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                 overflow_q, overflow_d;
    logic                 bad_frame_q, bad_frame_d;
    logic                 good_frame_q, good_frame_d;

    beat_t wr_beat;
    logic  mem_we;
    logic  full, full_wr, empty;
    logic  s_ready, s_hs, m_hs, rd_en, bad_user, drop_beat, drop_evt;

    // full: RAM holds DEPTH beats; full_wr: the open frame alone fills the RAM,
    // so it can never commit and must be drained rather than back-pressured.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign full_wr  = (wr_ptr_q - commit_ptr_q) == PW'(DEPTH);
    assign empty    = commit_ptr_q == rd_ptr_q;

    assign s_ready  = rst_n && ((DROP_WHEN_FULL != 0) || !full || drop_frame_q || full_wr);
    assign s_hs     = s_axis.tvalid && s_ready;
    assign m_hs     = m_valid_q && m_axis.tready;
    assign rd_en    = !empty && (!m_valid_q || m_axis.tready);
    assign bad_user = (USER_ENABLE != 0) &&
                      ((s_axis.tuser & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
    // Beats are discarded while a drop is in progress, when the frame is
    // oversize, or (in drop-when-full mode) when there is no room.
    assign drop_beat = drop_frame_q || full_wr || ((DROP_WHEN_FULL != 0) && full);

    // Pack the incoming beat, zeroing sidebands that are not stored.
    always_comb begin
        wr_beat      = '0;
        wr_beat.data = s_axis.tdata;
        wr_beat.keep = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;
        wr_beat.id   = (ID_ENABLE != 0)   ? s_axis.tid   : '0;
        wr_beat.dest = (DEST_ENABLE != 0) ? s_axis.tdest : '0;
        wr_beat.user = (USER_ENABLE != 0) ? s_axis.tuser : '0;
        wr_beat.last = s_axis.tlast;
    end

    // Write/commit/drop decisions, read-side output register and counters.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        commit_ptr_d  = commit_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        drop_frame_d  = drop_frame_q;
        m_valid_d     = m_valid_q;
        out_d         = out_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = 1'b0;
        bad_frame_d   = 1'b0;
        good_frame_d  = 1'b0;
        mem_we        = 1'b0;
        drop_evt      = 1'b0;

        if (s_hs) begin
            if (drop_beat) begin
                if (s_axis.tlast) begin
                    wr_ptr_d     = commit_ptr_q;
                    drop_frame_d = 1'b0;
                    overflow_d   = 1'b1;
                    drop_evt     = 1'b1;
                end else begin
                    drop_frame_d = 1'b1;
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (s_axis.tlast) begin
                    if ((DROP_BAD_FRAME != 0) && bad_user) begin
                        wr_ptr_d    = commit_ptr_q;
                        bad_frame_d = 1'b1;
                        drop_evt    = 1'b1;
                    end else begin
                        commit_ptr_d = wr_ptr_q + PW'(1);
                        good_frame_d = 1'b1;
                    end
                end
            end
        end

        // Only committed slots are visible here, so a same-cycle write to the
        // slot at rd_ptr can never be observed.
        if (m_hs) m_valid_d = 1'b0;
        if (rd_en) begin
            out_d     = mem[rd_ptr_q[AW-1:0]];
            m_valid_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + PW'(1);
        end

        case ({good_frame_d, m_hs && out_q.last})
            2'b10:   frame_count_d = frame_count_q + PW'(1);
            2'b01:   frame_count_d = frame_count_q - PW'(1);
            default: frame_count_d = frame_count_q;
        endcase

        if (drop_evt && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end

    // Beat storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_beat;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            drop_frame_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            out_q         <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            bad_frame_q   <= 1'b0;
            good_frame_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            drop_frame_q  <= drop_frame_d;
            m_valid_q     <= m_valid_d;
            out_q         <= out_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            bad_frame_q   <= bad_frame_d;
            good_frame_q  <= good_frame_d;
        end
    end

    assign s_axis.tready      = s_ready;
    assign m_axis.tvalid      = m_valid_q;
    assign m_axis.tdata       = out_q.data;
    assign m_axis.tkeep       = (KEEP_ENABLE != 0) ? out_q.keep : '1;
    assign m_axis.tlast       = out_q.last;
    assign m_axis.tid         = (ID_ENABLE != 0)   ? out_q.id   : '0;
    assign m_axis.tdest       = (DEST_ENABLE != 0) ? out_q.dest : '0;
    assign m_axis.tuser       = (USER_ENABLE != 0) ? out_q.user : '0;
    assign status_frame_count = frame_count_q;
    assign status_overflow    = overflow_q;
    assign status_bad_frame   = bad_frame_q;
    assign status_good_frame  = good_frame_q;
    assign drop_count         = drop_count_q;
endmodule
